canvas_scanner: RTL and testbench
=================================

// Module: canvas_scanner
// PURPOSE
// Read side of the mem_core cell store: scans the displayed bank one 128-bit row per
// display line and converts it to a pixel stream for the VGA output path. Cells are
// magnified CELL_SIZE x CELL_SIZE (128x96 cells -> 640x480). Bank select is latched once
// per frame, so the evolve engine may write the other bank without tearing.
// PARAMETERS
// CANVAS_WIDTH   128    cells per row (= mem_core data width)
// CANVAS_HEIGHT  96     rows per frame
// CELL_SIZE      5      pixels per cell edge, both axes
// ALIVE_COLOR    8'hFF  rgb for a live cell
// WALL_COLOR     8'h1C  rgb for edge cells when wall_en=1
// BG_COLOR       8'h00  rgb for dead cells, out-of-canvas pixels and underrun
// PORTS
// clk          in   1    system clock
// rst_n        in   1    synchronous reset, active low
// frame_start  in   1    1-cycle pulse in vertical blanking, before the first line
// line_start   in   1    1-cycle pulse in horizontal blanking, >=4 cycles before first pix_valid
// pix_valid    in   1    active-pixel strobe, contiguous per line
// bank_sel_in  in   1    bank the evolve engine marks as displayable
// wall_en      in   1    draw border cells in WALL_COLOR (wall mode)
// mem_addr     out  10   row address to both mem_core instances
// mem_dout0    in   128  read data, bank 0 (1-cycle read latency)
// mem_dout1    in   128  read data, bank 1
// disp_bank    out  1    bank currently displayed
// rgb_out      out  8    pixel colour
// rgb_valid    out  1    pix_valid delayed 1 cycle
// underrun     out  1    sticky: pixel requested before row fetch completed
// BEHAVIOUR
// - Reset: mem_addr=0, disp_bank=0, rgb_out=BG_COLOR, rgb_valid=0, underrun=0, FSM IDLE,
//   all counters 0, line buffer 0, buf_valid=0.
// - frame_start: disp_bank<=bank_sel_in; row_idx<=0, row_sub<=0; underrun<=0; first_line<=1.
// - line_start: if first_line, clear it and keep row 0; else row_sub++, wrapping at
//   CELL_SIZE-1 to 0 with row_idx++. row_idx saturates at CANVAS_HEIGHT (= off-canvas).
//   col_idx<=0, col_sub<=0, buf_valid<=0, start fetch.
// - Fetch FSM: IDLE -> ADDR (mem_addr<=row_idx) -> WAIT (RAM latency) -> LOAD
//   (line_buf<=disp_bank ? mem_dout1 : mem_dout0; buf_valid<=1) -> IDLE. 3 cycles after
//   line_start. Off-canvas row: skip fetch, buf_valid<=1, line_buf<=0.
// - line_start during ADDR/WAIT/LOAD restarts at ADDR with the new row; no stale load.
// - frame_start and line_start same cycle: frame_start applied first, line is row 0.
// - Bit order: cell x is line_buf[CANVAS_WIDTH-1-x]; MSB is leftmost.
// - Per pix_valid cycle: colour from line_buf MSB: wall (wall_en and x=0, x=W-1, row 0 or
//   row H-1) > alive > BG. col_sub++; at CELL_SIZE-1 -> 0, line_buf<<=1, col_idx++.
//   col_idx >= CANVAS_WIDTH -> BG_COLOR. pix_valid low: counters hold.
// - pix_valid with buf_valid=0: rgb_out=BG_COLOR, underrun<=1, counters still advance.
// - Output latency 1 cycle: rgb_out/rgb_valid registered from the pix_valid cycle.
// - bank_sel_in changes mid-frame: ignored until next frame_start.
// - rst_n low mid-fetch or mid-line: immediate return to reset state on next clk edge.
// TESTING
// - Bank 0 row 0 = 128'h8000..0001, frame_start, line_start, 640 pix_valid -> pixels 0-4 and
//   635-639 ALIVE_COLOR, 5-634 BG_COLOR; rgb_valid 1 cycle after pix_valid.
// - 480 lines, row r bit127 = r[0] -> pixel 0 alternates every 5 lines; mem_addr 0..95 step
//   per 5 line_starts, issued 1 cycle after line_start.
// - bank_sel_in=1 mid-frame, banks differ -> rest of frame shows bank 0; next frame bank 1.
// - wall_en=1, all-zero bank -> line 0 all WALL_COLOR; line 5: pixels 0-4 and 635-639 wall.
// - pix_valid 1 cycle after line_start -> rgb BG_COLOR, underrun=1 until next frame_start.
// - line_start twice 1 cycle apart, then rst_n low 1 cycle mid-fetch -> single load of
//   latest row, then all outputs at reset values, FSM IDLE.

Source files
------------

// File: rtl/canvas_scanner_if.sv
// Display-side bundle of canvas_scanner: video timing in, cell-store read port, pixel stream out.
interface canvas_scanner_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10
);
  logic              frame_start;
  logic              line_start;
  logic              pix_valid;
  logic              bank_sel_in;
  logic              wall_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout0;
  logic [DATA_W-1:0] mem_dout1;
  logic              disp_bank;
  logic [7:0]        rgb_out;
  logic              rgb_valid;
  logic              underrun;

  modport master (
    input  frame_start, line_start, pix_valid, bank_sel_in, wall_en, mem_dout0, mem_dout1,
    output mem_addr, disp_bank, rgb_out, rgb_valid, underrun
  );

  modport slave (
    output frame_start, line_start, pix_valid, bank_sel_in, wall_en, mem_dout0, mem_dout1,
    input  mem_addr, disp_bank, rgb_out, rgb_valid, underrun
  );
endinterface

// File: rtl/canvas_scanner.sv
// Scans the displayed cell-store bank one row per display line and expands each cell into a
// CELL_SIZE x CELL_SIZE block of pixels; the bank is latched once per frame to avoid tearing.
module canvas_scanner #(
  parameter int         CANVAS_WIDTH  = 128,
  parameter int         CANVAS_HEIGHT = 96,
  parameter int         CELL_SIZE     = 5,
  parameter logic [7:0] ALIVE_COLOR   = 8'hFF,
  parameter logic [7:0] WALL_COLOR    = 8'h1C,
  parameter logic [7:0] BG_COLOR      = 8'h00
) (
  input logic              clk,
  input logic              rst_n,
  canvas_scanner_if.master bus
);
  localparam int ADDR_W = 10;
  localparam int ROW_W  = $clog2(CANVAS_HEIGHT + 1);
  localparam int COL_W  = $clog2(CANVAS_WIDTH + 1);
  localparam int SUB_W  = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

  localparam logic [ROW_W-1:0] ROW_OFF  = ROW_W'(CANVAS_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CANVAS_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_OFF  = COL_W'(CANVAS_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CANVAS_WIDTH - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, LOAD} fetch_state_e;

  fetch_state_e            state_q, state_d;
  logic                    fetch_start;
  logic                    addr_en;
  logic                    load_en;

  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    disp_bank_q, disp_bank_d;
  logic [ROW_W-1:0]        row_idx_q, row_idx_d;
  logic [SUB_W-1:0]        row_sub_q, row_sub_d;
  logic [COL_W-1:0]        col_idx_q, col_idx_d;
  logic [SUB_W-1:0]        col_sub_q, col_sub_d;
  logic                    first_line_q, first_line_d;
  logic [CANVAS_WIDTH-1:0] line_buf_q, line_buf_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [7:0]              rgb_q, rgb_d;
  logic                    rgb_valid_q, rgb_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    on_wall;

  // Fetch FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch FSM: next state. A new line_start always wins so an in-flight fetch never lands.
  always_comb begin
    state_d = state_q;
    if (bus.line_start) begin
      state_d = fetch_start ? ADDR : IDLE;
    end else begin
      case (state_q)
        ADDR:    state_d = WAIT;
        WAIT:    state_d = LOAD;
        LOAD:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Fetch FSM: outputs
  always_comb begin
    addr_en = (state_q == ADDR) && !bus.line_start;
    load_en = (state_q == LOAD) && !bus.line_start;
  end

  always_comb begin
    on_wall = bus.wall_en && (row_idx_q != ROW_OFF) &&
              ((col_idx_q == '0) || (col_idx_q == COL_LAST) ||
               (row_idx_q == '0) || (row_idx_q == ROW_LAST));
  end

  // NOTE: every variable gets its hold value first, so no path through this block can infer a
  // latch; the later blocking assignments then layer frame, pixel, line and load effects in order.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    disp_bank_d  = disp_bank_q;
    row_idx_d    = row_idx_q;
    row_sub_d    = row_sub_q;
    col_idx_d    = col_idx_q;
    col_sub_d    = col_sub_q;
    first_line_d = first_line_q;
    line_buf_d   = line_buf_q;
    buf_valid_d  = buf_valid_q;
    underrun_d   = underrun_q;
    rgb_d        = BG_COLOR;
    rgb_valid_d  = bus.pix_valid;
    fetch_start  = 1'b0;

    if (bus.frame_start) begin
      disp_bank_d  = bus.bank_sel_in;
      row_idx_d    = '0;
      row_sub_d    = '0;
      underrun_d   = 1'b0;
      first_line_d = 1'b1;
    end

    if (bus.pix_valid) begin
      if (!buf_valid_q) begin
        underrun_d = 1'b1;
      end else if (col_idx_q != COL_OFF) begin
        if (on_wall)                          rgb_d = WALL_COLOR;
        else if (line_buf_q[CANVAS_WIDTH-1])  rgb_d = ALIVE_COLOR;
      end
      if (col_sub_q == SUB_LAST) begin
        col_sub_d  = '0;
        line_buf_d = line_buf_q << 1;
        if (col_idx_q != COL_OFF) col_idx_d = col_idx_q + 1'b1;
      end else begin
        col_sub_d = col_sub_q + 1'b1;
      end
    end

    // Row position advances on line_start; the first line of a frame stays on row 0.
    if (bus.line_start) begin
      if (first_line_d) begin
        first_line_d = 1'b0;
      end else if (row_sub_d == SUB_LAST) begin
        row_sub_d = '0;
        if (row_idx_d != ROW_OFF) row_idx_d = row_idx_d + 1'b1;
      end else begin
        row_sub_d = row_sub_d + 1'b1;
      end
      col_idx_d   = '0;
      col_sub_d   = '0;
      buf_valid_d = 1'b0;
      if (row_idx_d == ROW_OFF) begin
        buf_valid_d = 1'b1;
        line_buf_d  = '0;
      end else begin
        fetch_start = 1'b1;
      end
    end

    if (addr_en) mem_addr_d = ADDR_W'(row_idx_q);

    if (load_en) begin
      line_buf_d  = disp_bank_q ? bus.mem_dout1 : bus.mem_dout0;
      buf_valid_d = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: line_buf is plain flops, so it takes the reset with everything else and never holds X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q   <= '0;
      disp_bank_q  <= 1'b0;
      row_idx_q    <= '0;
      row_sub_q    <= '0;
      col_idx_q    <= '0;
      col_sub_q    <= '0;
      first_line_q <= 1'b0;
      line_buf_q   <= '0;
      buf_valid_q  <= 1'b0;
      rgb_q        <= BG_COLOR;
      rgb_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      disp_bank_q  <= disp_bank_d;
      row_idx_q    <= row_idx_d;
      row_sub_q    <= row_sub_d;
      col_idx_q    <= col_idx_d;
      col_sub_q    <= col_sub_d;
      first_line_q <= first_line_d;
      line_buf_q   <= line_buf_d;
      buf_valid_q  <= buf_valid_d;
      rgb_q        <= rgb_d;
      rgb_valid_q  <= rgb_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.disp_bank = disp_bank_q;
  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_canvas_scanner.sv
// Self-checking bench for canvas_scanner: a frame-level pixel model plus hand-computed spot checks.
module tb_canvas_scanner;
  localparam int W    = 128;
  localparam int H    = 96;
  localparam int CELL = 5;
  localparam logic [7:0] ALIVE = 8'hFF;
  localparam logic [7:0] WALL  = 8'h1C;
  localparam logic [7:0] BG    = 8'h00;

  logic clk;
  logic rst_n;
  canvas_scanner_if bus ();

  canvas_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] img0 [0:H-1];
  logic [W-1:0] img1 [0:H-1];

  // Two banks of single-cycle-latency read memory
  always @(posedge clk) begin
    if (int'(bus.mem_addr) < H) begin
      bus.mem_dout0 <= img0[int'(bus.mem_addr)];
      bus.mem_dout1 <= img1[int'(bus.mem_addr)];
    end else begin
      bus.mem_dout0 <= '0;
      bus.mem_dout1 <= '0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what the display should show after the edge that samples the current drive
  int         m_line;
  bit         m_first;
  bit         m_bank;
  bit         m_under;
  int         since_ls;
  bit         chk_en;
  bit         drv_valid_exp;
  logic [7:0] drv_rgb_exp;
  int         cur_pix;

  bit         e_active;
  bit         e_valid;
  logic [7:0] e_rgb;
  bit         e_under;
  bit         e_bank;
  int         e_pix;
  logic [7:0] cap [0:639];

  function automatic logic [7:0] exp_pixel(input int line, input int pix);
    int x;
    int y;
    logic [W-1:0] row;
    x = pix / CELL;
    y = line / CELL;
    if (y >= H || x >= W) return BG;
    if (bus.wall_en && (x == 0 || x == W - 1 || y == 0 || y == H - 1)) return WALL;
    row = m_bank ? img1[y] : img0[y];
    return row[W-1-x] ? ALIVE : BG;
  endfunction

  always @(posedge clk) begin
    e_active <= chk_en;
    e_valid  <= drv_valid_exp;
    e_rgb    <= drv_rgb_exp;
    e_under  <= m_under;
    e_bank   <= m_bank;
    e_pix    <= cur_pix;
  end

  always @(negedge clk) begin
    if (e_active) begin
      check("rgb_valid", {7'd0, bus.rgb_valid}, {7'd0, e_valid});
      if (e_valid) begin
        check("rgb_out", bus.rgb_out, e_rgb);
        cap[e_pix] = bus.rgb_out;
      end
      check("underrun", {7'd0, bus.underrun}, {7'd0, e_under});
      check("disp_bank", {7'd0, bus.disp_bank}, {7'd0, e_bank});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    since_ls++;
  endtask

  task automatic start_frame(input bit sel);
    bus.frame_start = 1'b1;
    bus.bank_sel_in = sel;
    m_bank  = sel;
    m_under = 1'b0;
    m_line  = 0;
    m_first = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_line(input bit fs, input bit sel);
    if (fs) begin
      bus.frame_start = 1'b1;
      bus.bank_sel_in = sel;
      m_bank  = sel;
      m_under = 1'b0;
      m_line  = 0;
      m_first = 1'b1;
    end
    bus.line_start = 1'b1;
    if (m_first) m_first = 1'b0;
    else         m_line++;
    since_ls = 0;
    tick();
    bus.line_start  = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic pix_run(input int min_since, input int npix);
    int  y;
    bit  rdy;
    y = m_line / CELL;
    while (since_ls < min_since) tick();
    for (int p = 0; p < npix; p++) begin
      rdy = (since_ls >= 4) || (y >= H);
      if (!rdy) m_under = 1'b1;
      bus.pix_valid = 1'b1;
      drv_valid_exp = 1'b1;
      drv_rgb_exp   = rdy ? exp_pixel(m_line, p) : BG;
      cur_pix       = p;
      tick();
    end
    bus.pix_valid = 1'b0;
    drv_valid_exp = 1'b0;
    tick();
    tick();
    if (y < H) check("mem_addr_row", {118'd0, bus.mem_addr}, 128'(y));
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < H; r++) begin
      logic [7:0] rb;
      rb = 8'(r);
      img0[r] = {rb[0], 1'b1, 118'd0, rb};
    end
    img0[0] = {1'b1, 126'd0, 1'b1};
    for (int r = 0; r < H; r++) img1[r] = ~img0[r];

    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.bank_sel_in = 1'b0;
    bus.wall_en     = 1'b0;
    chk_en = 1'b0; drv_valid_exp = 1'b0; drv_rgb_exp = BG; cur_pix = 0;
    m_line = 0; m_first = 1'b0; m_bank = 1'b0; m_under = 1'b0; since_ls = 0;
    repeat (3) tick();
    check("reset_mem_addr", {118'd0, bus.mem_addr}, 128'd0);
    check("reset_disp_bank", {127'd0, bus.disp_bank}, 128'd0);
    check("reset_rgb_out", {120'd0, bus.rgb_out}, {120'd0, BG});
    check("reset_rgb_valid", {127'd0, bus.rgb_valid}, 128'd0);
    check("reset_underrun", {127'd0, bus.underrun}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Frame A: bank 0, full scan, bank_sel_in flips mid-frame and must be ignored
    chk_en = 1'b1;
    start_frame(1'b0);
    for (int l = 0; l <= 480; l++) begin
      if (l == 200) bus.bank_sel_in = 1'b1;
      pulse_line(1'b0, 1'b0);
      if (l == 5) begin
        tick();
        check("mem_addr_line5_issue", {118'd0, bus.mem_addr}, 128'd1);
      end
      pix_run(4, (l == 0 || l == 1 || l == 5 || l == 100) ? 640 : 10);
      if (l == 0) begin
        check("A_l0_px0", {120'd0, cap[0]}, {120'd0, ALIVE});
        check("A_l0_px4", {120'd0, cap[4]}, {120'd0, ALIVE});
        check("A_l0_px5", {120'd0, cap[5]}, {120'd0, BG});
        check("A_l0_px634", {120'd0, cap[634]}, {120'd0, BG});
        check("A_l0_px635", {120'd0, cap[635]}, {120'd0, ALIVE});
        check("A_l0_px639", {120'd0, cap[639]}, {120'd0, ALIVE});
      end
      if (l == 5) check("A_l5_px9", {120'd0, cap[9]}, {120'd0, ALIVE});
      if (l == 100) begin
        check("A_l100_px0", {120'd0, cap[0]}, {120'd0, BG});
        check("A_l100_px5", {120'd0, cap[5]}, {120'd0, ALIVE});
      end
    end
    check("A_last_mem_addr", {118'd0, bus.mem_addr}, 128'd95);
    check("A_bank_held", {127'd0, bus.disp_bank}, 128'd0);

    // Frame B: bank 1 now latched
    start_frame(1'b1);
    check("B_disp_bank", {127'd0, bus.disp_bank}, 128'd1);
    for (int l = 0; l < 6; l++) begin
      pulse_line(1'b0, 1'b0);
      pix_run(4, 640);
      if (l == 0) begin
        check("B_l0_px0", {120'd0, cap[0]}, {120'd0, BG});
        check("B_l0_px5", {120'd0, cap[5]}, {120'd0, ALIVE});
        check("B_l0_px639", {120'd0, cap[639]}, {120'd0, BG});
      end
    end

    // Frame E: underrun, back-to-back line_start, reset mid-fetch
    pulse_line(1'b1, 1'b1);
    pix_run(1, 20);
    check("E_underrun_set", {127'd0, bus.underrun}, 128'd1);
    for (int l = 1; l < 4; l++) begin
      pulse_line(1'b0, 1'b0);
      pix_run(4, 10);
    end
    check("E_underrun_sticky", {127'd0, bus.underrun}, 128'd1);
    pulse_line(1'b0, 1'b0);
    pulse_line(1'b0, 1'b0);
    pix_run(4, 20);
    check("E_dbl_row1_px5", {120'd0, cap[5]}, {120'd0, BG});
    check("E_dbl_row1_px0", {120'd0, cap[0]}, {120'd0, BG});
    pulse_line(1'b0, 1'b0);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("rst_mid_mem_addr", {118'd0, bus.mem_addr}, 128'd0);
    check("rst_mid_disp_bank", {127'd0, bus.disp_bank}, 128'd0);
    check("rst_mid_rgb_out", {120'd0, bus.rgb_out}, {120'd0, BG});
    check("rst_mid_rgb_valid", {127'd0, bus.rgb_valid}, 128'd0);
    check("rst_mid_underrun", {127'd0, bus.underrun}, 128'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_no_late_load_addr", {118'd0, bus.mem_addr}, 128'd0);
    bus.pix_valid = 1'b1;
    tick();
    check("post_rst_rgb_valid", {127'd0, bus.rgb_valid}, 128'd1);
    check("post_rst_rgb_bg", {120'd0, bus.rgb_out}, {120'd0, BG});
    tick();
    bus.pix_valid = 1'b0;
    tick();
    check("post_rst_underrun", {127'd0, bus.underrun}, 128'd1);

    // Frame C: wall mode on an all-dead bank, frame_start and line_start together
    for (int r = 0; r < H; r++) img1[r] = '0;
    bus.wall_en = 1'b1;
    chk_en = 1'b1;
    pulse_line(1'b1, 1'b1);
    pix_run(4, 640);
    check("C_l0_px0", {120'd0, cap[0]}, {120'd0, WALL});
    check("C_l0_px300", {120'd0, cap[300]}, {120'd0, WALL});
    check("C_l0_px639", {120'd0, cap[639]}, {120'd0, WALL});
    check("C_underrun_cleared", {127'd0, bus.underrun}, 128'd0);
    for (int l = 1; l < 480; l++) begin
      pulse_line(1'b0, 1'b0);
      pix_run(4, (l == 5 || l == 479) ? 640 : 10);
      if (l == 5) begin
        check("C_l5_px0", {120'd0, cap[0]}, {120'd0, WALL});
        check("C_l5_px4", {120'd0, cap[4]}, {120'd0, WALL});
        check("C_l5_px5", {120'd0, cap[5]}, {120'd0, BG});
        check("C_l5_px634", {120'd0, cap[634]}, {120'd0, BG});
        check("C_l5_px635", {120'd0, cap[635]}, {120'd0, WALL});
      end
      if (l == 479) check("C_l479_px320", {120'd0, cap[320]}, {120'd0, WALL});
    end
    chk_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
